tx_flush_scheduler: RTL and testbench
=====================================

Name: tx_flush_scheduler

Overview:
- TX-side counterpart of the RX flush/escape removal stage.
- Sits between the TX lane data source and the lane striper.
- Escapes payload words equal to ESC_PACK by sending them as an ESC_PACK,ESC_PACK pair.
- Schedules flush filler (ESC_PACK,FLUSH_PACK pairs) to push residual data through the link. Filler is inserted after an idle timeout or on explicit request.
- A payload word equal to FLUSH_PACK passes unescaped.

Parameters:
DATA_W, 64, word width (UNITWIDTH*LANENUMBER)
ESC_PACK, 64'hFEFE_FEFE_FEFE_FEFE, escape word value
FLUSH_PACK, 64'hF7F7_F7F7_F7F7_F7F7, flush word value
IDLE_TIMEOUT, 16, idle cycles (dirty stream) before auto-flush; range 1..65535
FLUSH_PAIRS, 2, filler pairs emitted per flush; range 1..15

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_enable  in  1  global enable; low freezes all state
in_data  in  DATA_W  payload word
in_valid  in  1  payload valid
in_ready  out  1  payload accepted when in_valid&&in_ready
flush_req  in  1  single-cycle request to force a flush
out_data  out  DATA_W  word to striper
out_valid  out  1  output valid
out_ready  in  1  downstream accept
flush_active  out  1  high while filler sequence in progress
flush_done  out  1  one-cycle pulse when the last filler word is accepted

Behaviour:
- Reset values (reset_n low at posedge clk): out_data=0, out_valid=0, flush_done=0, flush_active=0.
- Reset also clears internal state: state=PASS, dirty=0, flush_pend=0, idle_cnt=0, pair_cnt=0.
- Reset mid-sequence abandons any escape or flush immediately.
- Output is a single register. ld = !out_valid || out_ready.
- ld: out_valid/out_data may be written this cycle. If ld and nothing is to be emitted, out_valid<=0.
- in_enable=0:
  - No register changes.
  - in_ready=0.
  - out_valid/out_data held.
  - flush_req ignored.
- flush_pend:
  - Set by flush_req (when enabled).
  - Set by timer expiry: idle_cnt==IDLE_TIMEOUT-1 while counting.
  - Cleared when a flush sequence starts.
- idle_cnt:
  - Increments when enabled, state==PASS, dirty=1, no input handshake.
  - Cleared on any input handshake and on flush start.
  - Saturates at IDLE_TIMEOUT-1.
- dirty: set on any input handshake; cleared on flush completion.
- flush_go = flush_pend || (flush_req && state==PASS).
- in_ready = in_enable && state==PASS && ld && !flush_go.
- States:
  - PASS:
    - If ld && flush_go: emit ESC_PACK, pair_cnt<=0, flush_active<=1, ->FL_WORD.
    - Else on input handshake, in_data==ESC_PACK: emit ESC_PACK, ->ESC2.
    - Else on input handshake with any other value (incl. FLUSH_PACK): emit in_data, stay.
  - ESC2: when ld, emit ESC_PACK, ->PASS. No input accepted.
  - FL_ESC: when ld, emit ESC_PACK, ->FL_WORD.
  - FL_WORD: when ld, emit FLUSH_PACK.
    - If pair_cnt==FLUSH_PAIRS-1: ->FL_LAST.
    - Else pair_cnt++, ->FL_ESC.
  - FL_LAST: waits for the final FLUSH_PACK to be accepted (out_valid&&out_ready).
    - Then flush_done=1 for one cycle, flush_active<=0, dirty<=0, idle_cnt<=0, ->PASS.
    - The same-cycle ld path may accept new input only from the following cycle.
- Atomicity:
  - An ESC_PACK pair is never split by a flush.
  - flush_req arriving in ESC2 or during a flush is latched into flush_pend.
  - It is served at the next PASS boundary, yielding a new full sequence.
- Latency: one cycle from input handshake to out_valid for non-escaped words.
- Throughput: 1 word/cycle when out_ready=1 and no escapes or flushes.
- Backpressure (out_ready=0) holds out_data stable; no word is dropped or duplicated.
- Auto-flush never triggers when dirty=0. flush_req always produces a full sequence.

Test Plan:
- Reset then stream 0x1..0x8, out_ready=1:
  - outputs 0x1..0x8 one cycle after each accept.
  - in_ready stays 1.
  - After 16 idle cycles, emits ESC,FLUSH,ESC,FLUSH; flush_done pulses once; no further flush while idle.
- in_data=ESC_PACK then 0x5:
  - outputs ESC_PACK,ESC_PACK,0x5.
  - in_ready=0 in the cycle after the ESC accept.
- in_data=FLUSH_PACK: output FLUSH_PACK unescaped, one word only.
- flush_req in ESC2 cycle:
  - sequence ESC,ESC, then ESC,FLUSH,ESC,FLUSH.
  - flush_active rises only after the escape pair.
- out_ready toggling 1/0 every cycle during a flush:
  - every word is held while out_ready=0.
  - exactly 4 filler words are accepted; flush_done is aligned with the accept of the 4th.
- in_enable=0 for 10 cycles mid-flush with pending idle time: no outputs change, idle_cnt frozen; resumes identically afterwards. Then assert reset_n=0 mid-flush: out_valid=0, flush_active=0 next cycle.

Source files
------------

// File: rtl/tx_flush_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_flush_scheduler_if
//
// Purpose: bundles the payload-in, word-out and flush control signals of the
// TX flush/escape insertion stage so they travel as one port.
//
// Signals:
//   in_enable     global enable; low freezes the scheduler
//   in_data       payload word from the TX lane data source
//   in_valid      payload valid
//   in_ready      payload accepted when in_valid && in_ready
//   flush_req     single-cycle request to force a flush
//   out_data      word towards the lane striper
//   out_valid     out_data holds a word
//   out_ready     striper accepts out_data
//   flush_active  filler sequence in progress
//   flush_done    one-cycle pulse after the last filler word is accepted
//
// Modports:
//   master  source/sink side (drives payload, flush_req, out_ready)
//   slave   scheduler side
// ---------------------------------------------------------------------------
interface tx_flush_scheduler_if #(
   parameter int DATA_W = 64
) ();
   logic              in_enable;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              flush_req;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              flush_active;
   logic              flush_done;

   modport master (
      output in_enable, in_data, in_valid, flush_req, out_ready,
      input  in_ready, out_data, out_valid, flush_active, flush_done
   );

   modport slave (
      input  in_enable, in_data, in_valid, flush_req, out_ready,
      output in_ready, out_data, out_valid, flush_active, flush_done
   );
endinterface

// File: rtl/tx_flush_scheduler.sv
// ---------------------------------------------------------------------------
// tx_flush_scheduler
//
// Purpose: TX-side escape insertion and flush filler scheduling, sitting
// between the TX lane data source and the lane striper.
//   - A payload word equal to ESC_PACK goes out as ESC_PACK,ESC_PACK.
//   - A payload word equal to FLUSH_PACK goes out unchanged.
//   - Flush filler (FLUSH_PAIRS x ESC_PACK,FLUSH_PACK) is sent after
//     IDLE_TIMEOUT idle cycles on a dirty stream, or on flush_req.
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      tx_flush_scheduler_if.slave (payload in, word out, flush ctl)
//
// The output is one register; ld marks the cycles in which it may be
// (re)written. Everything, including the output register, freezes while
// in_enable is low.
// ---------------------------------------------------------------------------
module tx_flush_scheduler #(
   parameter int                DATA_W       = 64,
   parameter logic [DATA_W-1:0] ESC_PACK     = 64'hFEFE_FEFE_FEFE_FEFE,
   parameter logic [DATA_W-1:0] FLUSH_PACK   = 64'hF7F7_F7F7_F7F7_F7F7,
   parameter int                IDLE_TIMEOUT = 16,
   parameter int                FLUSH_PAIRS  = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   tx_flush_scheduler_if.slave  bus
);

   localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
   localparam logic [3:0]  PAIR_LAST = 4'(FLUSH_PAIRS - 1);

   typedef enum logic [2:0] {
      PASS,      // payload pass-through
      ESC2,      // second half of an escaped payload word
      FL_ESC,    // filler: ESC_PACK of the next pair
      FL_WORD,   // filler: FLUSH_PACK of the current pair
      FL_LAST    // waiting for the final FLUSH_PACK to be accepted
   } state_t;

   state_t            state_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_valid_reg;
   logic              flush_active_reg;
   logic              flush_done_reg;
   logic              dirty_reg;
   logic              flush_pend_reg;
   logic [15:0]       idle_cnt_reg;
   logic [3:0]        pair_cnt_reg;

   logic ld;
   logic in_pass;
   logic flush_go;
   logic in_ready_int;
   logic in_hs;
   logic counting;
   logic timer_hit;

   always_comb begin
      ld           = !out_valid_reg || bus.out_ready;
      in_pass      = (state_reg == PASS);
      // A request seen in PASS is served in the same cycle; elsewhere it is
      // parked in flush_pend so escape pairs and running fills stay whole.
      flush_go     = flush_pend_reg || (bus.flush_req && in_pass);
      in_ready_int = bus.in_enable && in_pass && ld && !flush_go;
      in_hs        = bus.in_valid && in_ready_int;
      counting     = in_pass && dirty_reg && !in_hs;
      timer_hit    = counting && (idle_cnt_reg == IDLE_LAST);
   end

   assign bus.in_ready     = in_ready_int;
   assign bus.out_data     = out_data_reg;
   assign bus.out_valid    = out_valid_reg;
   assign bus.flush_active = flush_active_reg;
   assign bus.flush_done   = flush_done_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg        <= PASS;
         out_data_reg     <= '0;
         out_valid_reg    <= 1'b0;
         flush_active_reg <= 1'b0;
         flush_done_reg   <= 1'b0;
         dirty_reg        <= 1'b0;
         flush_pend_reg   <= 1'b0;
         idle_cnt_reg     <= '0;
         pair_cnt_reg     <= '0;
      end else if (bus.in_enable) begin
         flush_done_reg <= 1'b0;

         // Idle timer: counts only on a dirty stream in PASS, saturating.
         if (in_hs) begin
            dirty_reg    <= 1'b1;
            idle_cnt_reg <= '0;
         end else if (counting && (idle_cnt_reg != IDLE_LAST)) begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
         end

         // Set here; a flush start below overrides with a clear.
         if (bus.flush_req || timer_hit) begin
            flush_pend_reg <= 1'b1;
         end

         case (state_reg)
            PASS: begin
               if (ld && flush_go) begin
                  out_data_reg     <= ESC_PACK;
                  out_valid_reg    <= 1'b1;
                  pair_cnt_reg     <= '0;
                  flush_active_reg <= 1'b1;
                  flush_pend_reg   <= 1'b0;
                  idle_cnt_reg     <= '0;
                  state_reg        <= FL_WORD;
               end else if (in_hs) begin
                  out_valid_reg <= 1'b1;
                  if (bus.in_data == ESC_PACK) begin
                     out_data_reg <= ESC_PACK;
                     state_reg    <= ESC2;
                  end else begin
                     out_data_reg <= bus.in_data;
                  end
               end else if (ld) begin
                  out_valid_reg <= 1'b0;
               end
            end

            ESC2: begin
               if (ld) begin
                  out_data_reg  <= ESC_PACK;
                  out_valid_reg <= 1'b1;
                  state_reg     <= PASS;
               end
            end

            FL_ESC: begin
               if (ld) begin
                  out_data_reg  <= ESC_PACK;
                  out_valid_reg <= 1'b1;
                  state_reg     <= FL_WORD;
               end
            end

            FL_WORD: begin
               if (ld) begin
                  out_data_reg  <= FLUSH_PACK;
                  out_valid_reg <= 1'b1;
                  if (pair_cnt_reg == PAIR_LAST) begin
                     state_reg <= FL_LAST;
                  end else begin
                     pair_cnt_reg <= pair_cnt_reg + 4'd1;
                     state_reg    <= FL_ESC;
                  end
               end
            end

            FL_LAST: begin
               // New input is only taken from the cycle after completion,
               // so the output register simply empties here.
               if (out_valid_reg && bus.out_ready) begin
                  flush_done_reg   <= 1'b1;
                  flush_active_reg <= 1'b0;
                  dirty_reg        <= 1'b0;
                  idle_cnt_reg     <= '0;
                  out_valid_reg    <= 1'b0;
                  state_reg        <= PASS;
               end
            end

            default: begin
               state_reg <= PASS;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_flush_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_flush_scheduler
//
// Directed bench for tx_flush_scheduler. A queue holds the words the striper
// must receive, built from the stream rules (payload words, doubled escapes,
// filler sequences). One monitor process checks the outputs every cycle
// against that queue, plus hold, latency and flush_done alignment rules.
// Directed steps add literal expectations (timeout gaps, pulse counts).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_flush_scheduler;
   localparam int          DATA_W = 64;
   localparam int          PAIRS  = 2;
   localparam logic [63:0] ESC    = 64'hFEFE_FEFE_FEFE_FEFE;
   localparam logic [63:0] FLS    = 64'hF7F7_F7F7_F7F7_F7F7;

   logic clk = 1'b0;
   logic reset_n;

   tx_flush_scheduler_if #(.DATA_W(DATA_W)) bus_if ();

   tx_flush_scheduler #(
      .DATA_W(DATA_W), .ESC_PACK(ESC), .FLUSH_PACK(FLS),
      .IDLE_TIMEOUT(16), .FLUSH_PAIRS(PAIRS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] w;
      logic        fill;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   fill_acc = 0;
   int   done_cnt = 0;
   int   last_plain_cyc = 0;
   int   fill_start_cyc = 0;
   bit   chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void push_exp(input logic [63:0] w, input logic f, input logic l);
      exp_t e;
      e.w = w; e.fill = f; e.last = l;
      exp_q.push_back(e);
   endfunction

   function automatic void push_input(input logic [63:0] w);
      if (w == ESC) begin
         push_exp(ESC, 1'b0, 1'b0);
         push_exp(ESC, 1'b0, 1'b0);
      end else begin
         push_exp(w, 1'b0, 1'b0);
      end
   endfunction

   function automatic void push_fill();
      for (int p = 0; p < PAIRS; p++) begin
         push_exp(ESC, 1'b1, 1'b0);
         push_exp(FLS, 1'b1, p == PAIRS - 1);
      end
   endfunction

   // ---------------- per-cycle monitor ----------------
   initial begin
      bit          have_prev, p_en, p_valid, p_ready, p_act, p_done, p_done_exp, p_fill_vis;
      bit          lat_pend, cur_fill_vis, done_exp;
      logic [63:0] p_data, lat_word;
      exp_t        h;
      have_prev = 0; lat_pend = 0; p_fill_vis = 0; p_done_exp = 0;
      p_en = 0; p_valid = 0; p_ready = 0; p_act = 0; p_done = 0;
      p_data = '0; lat_word = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n || !chk_en) begin
            have_prev = 0; lat_pend = 0; p_fill_vis = 0; p_done_exp = 0;
         end else begin
            if (have_prev && !p_en) begin
               chk("hold_disabled_data", bus_if.out_data, p_data);
               chk("hold_disabled_ctl",
                   64'({bus_if.out_valid, bus_if.flush_active, bus_if.flush_done}),
                   64'({p_valid, p_act, p_done}));
            end else if (have_prev && p_valid && !p_ready) begin
               chk("hold_backpressure",
                   64'({bus_if.out_valid, bus_if.out_data}) , 64'({1'b1, p_data}));
            end
            if (have_prev && p_en) begin
               chk("flush_done_align", 64'(bus_if.flush_done), 64'(p_done_exp));
               if (bus_if.flush_done) done_cnt++;
            end
            if (lat_pend) begin
               chk("latency_valid", 64'(bus_if.out_valid), 64'd1);
               chk("latency_data", bus_if.out_data, lat_word);
            end
            lat_pend = 0;

            cur_fill_vis = 0;
            if (bus_if.out_valid) begin
               chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  h = exp_q[0];
                  chk("out_data", bus_if.out_data, h.w);
                  chk("flush_active", 64'(bus_if.flush_active), 64'(h.fill));
                  cur_fill_vis = h.fill;
                  if (!h.fill) last_plain_cyc = cyc;
               end
            end else begin
               chk("flush_active_idle", 64'(bus_if.flush_active), 64'd0);
            end
            if (cur_fill_vis && !p_fill_vis) fill_start_cyc = cyc;

            done_exp = 0;
            if (bus_if.in_enable && bus_if.out_valid && bus_if.out_ready && exp_q.size() != 0) begin
               h = exp_q.pop_front();
               if (h.fill) fill_acc++;
               done_exp = h.last;
            end

            if (bus_if.in_enable && bus_if.in_valid && bus_if.in_ready) begin
               push_input(bus_if.in_data);
               lat_pend = 1;
               lat_word = (bus_if.in_data == ESC) ? ESC : bus_if.in_data;
            end
            if (bus_if.in_enable && bus_if.flush_req) push_fill();

            p_en = bus_if.in_enable; p_valid = bus_if.out_valid; p_ready = bus_if.out_ready;
            p_data = bus_if.out_data; p_act = bus_if.flush_active; p_done = bus_if.flush_done;
            p_done_exp = done_exp; p_fill_vis = cur_fill_vis;
            have_prev = 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w, input bit want_ready_now);
      int guard;
      bit fin;
      guard = 0; fin = 0;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = w;
      while (!fin) begin
         @(negedge clk);
         if (guard == 0 && want_ready_now) chk("in_ready_first_try", 64'(bus_if.in_ready), 64'd1);
         if (bus_if.in_ready) begin
            fin = 1;
         end else if (guard > 100) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout actual=no_accept required=accept word=%h", w);
            fin = 1;
         end
         guard++;
         @(posedge clk);
         #1;
      end
      bus_if.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 300) begin
         step();
         g++;
      end
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int b_fill, b_done, g;
      reset_n = 1'b0;
      bus_if.in_enable = 1'b1;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = 64'h99;
      bus_if.flush_req = 1'b1;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("rst_out_data", bus_if.out_data, 64'd0);
      chk("rst_flush_active", 64'(bus_if.flush_active), 64'd0);
      chk("rst_flush_done", 64'(bus_if.flush_done), 64'd0);
      step();
      bus_if.in_valid = 1'b0;
      bus_if.flush_req = 1'b0;
      step();
      reset_n = 1'b1;
      chk_en = 1'b1;
      step();

      // T1: stream 1..8, then auto-flush after the idle timeout
      b_done = done_cnt;
      for (int i = 1; i <= 8; i++) send(64'(i), 1'b1);
      push_fill();
      drain();
      chk("t1_idle_gap", 64'(fill_start_cyc - last_plain_cyc), 64'd17);
      repeat (40) step();
      chk("t1_done_pulses", 64'(done_cnt - b_done), 64'd1);
      chk("t1_quiet_after", 64'(bus_if.out_valid), 64'd0);

      // T2: escaped word followed by a plain word
      send(ESC, 1'b1);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 64'h5;
      @(negedge clk);
      chk("t2_ready_after_esc", 64'(bus_if.in_ready), 64'd0);
      step();
      send(64'h5, 1'b0);
      push_fill();
      drain();

      // T3: FLUSH_PACK payload passes unescaped
      send(FLS, 1'b1);
      push_fill();
      drain();

      // T4: flush request during the second half of an escape pair
      b_done = done_cnt; b_fill = fill_acc;
      send(ESC, 1'b1);
      bus_if.flush_req = 1'b1;
      @(negedge clk);
      chk("t4_ready_in_esc2", 64'(bus_if.in_ready), 64'd0);
      chk("t4_no_active_in_esc2", 64'(bus_if.flush_active), 64'd0);
      step();
      bus_if.flush_req = 1'b0;
      drain();
      repeat (40) step();
      chk("t4_fill_accepts", 64'(fill_acc - b_fill), 64'd4);
      chk("t4_done_pulses", 64'(done_cnt - b_done), 64'd1);

      // T5: out_ready toggling during a requested flush
      b_done = done_cnt; b_fill = fill_acc;
      bus_if.flush_req = 1'b1;
      bus_if.out_ready = 1'b0;
      step();
      bus_if.flush_req = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus_if.out_ready = ~bus_if.out_ready;
         step();
      end
      bus_if.out_ready = 1'b1;
      drain();
      chk("t5_fill_accepts", 64'(fill_acc - b_fill), 64'd4);
      chk("t5_done_pulses", 64'(done_cnt - b_done), 64'd1);

      // T6: enable dropped during idle counting and again mid-flush
      b_done = done_cnt; b_fill = fill_acc;
      send(64'h11, 1'b1);
      send(64'h12, 1'b1);
      send(64'h13, 1'b1);
      push_fill();
      repeat (5) step();
      bus_if.in_enable = 1'b0;
      repeat (10) step();
      bus_if.in_enable = 1'b1;
      g = 0;
      while (fill_acc == b_fill && g < 200) begin step(); g++; end
      bus_if.in_enable = 1'b0;
      repeat (10) step();
      bus_if.in_enable = 1'b1;
      drain();
      chk("t6_frozen_gap", 64'(fill_start_cyc - last_plain_cyc), 64'd27);
      chk("t6_fill_accepts", 64'(fill_acc - b_fill), 64'd4);
      chk("t6_done_pulses", 64'(done_cnt - b_done), 64'd1);

      // T7: reset in the middle of a flush
      b_fill = fill_acc;
      bus_if.flush_req = 1'b1;
      step();
      bus_if.flush_req = 1'b0;
      g = 0;
      while (fill_acc - b_fill < 2 && g < 200) begin step(); g++; end
      chk_en = 1'b0;
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t7_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("t7_rst_flush_active", 64'(bus_if.flush_active), 64'd0);
      chk("t7_rst_flush_done", 64'(bus_if.flush_done), 64'd0);
      chk("t7_rst_out_data", bus_if.out_data, 64'd0);
      step();
      reset_n = 1'b1;
      exp_q.delete();
      chk_en = 1'b1;
      send(64'h42, 1'b1);
      push_fill();
      drain();
      chk("t7_idle_gap", 64'(fill_start_cyc - last_plain_cyc), 64'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
